// File: rtl/perf_frame_rx.sv
// perf_frame_rx: reassembles 6-byte cache performance frames from a UART byte stream.
// Frame byte order: L1I miss, L1I access, L1D miss, L1D access, L2 miss, L2 access.
// The last complete frame is held on the field outputs. A one-cycle frame_valid pulse
// marks each completion. frame_err flags a frame where misses exceed accesses, and a
// partial frame that stalls for GAP_CYCLES is dropped with a gap_err pulse.
// Optional feature macro: PERF_HITS_EN adds saturating hit-count outputs (acc - miss).
module perf_frame_rx #(
    parameter int GAP_CYCLES = 1000,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             frame_valid,
    output logic [7:0]       l1i_miss,
    output logic [7:0]       l1i_acc,
    output logic [7:0]       l1d_miss,
    output logic [7:0]       l1d_acc,
    output logic [7:0]       l2_miss,
    output logic [7:0]       l2_acc,
    output logic             frame_err,
    output logic             gap_err,
`ifdef PERF_HITS_EN
    output logic [7:0]       l1i_hit,
    output logic [7:0]       l1d_hit,
    output logic [7:0]       l2_hit,
`endif
    output logic [CNT_W-1:0] frame_cnt
);

    // Timer counts idle cycles 0..GAP_CYCLES-1; the edge seen with TMR_LAST and no byte is the timeout.
    localparam int TMR_W = $clog2(GAP_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GAP_CYCLES - 1);
    localparam logic [2:0] IDX_LAST = 3'd5;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    // Unsigned 8-bit consistency test for one cache level.
    function automatic logic miss_gt_acc(input logic [7:0] miss, input logic [7:0] acc);
        return (miss > acc);
    endfunction

`ifdef PERF_HITS_EN
    // Hit count for one cache level, clamped at zero for an inconsistent level.
    function automatic logic [7:0] sat_hits(input logic [7:0] acc, input logic [7:0] miss);
        logic [7:0] res;
        if (miss > acc) begin
            res = 8'd0;
        end else begin
            res = acc - miss;
        end
        return res;
    endfunction
`endif

    state_t           state_q;
    logic [2:0]       idx_q;
    logic [TMR_W-1:0] timer_q;
    logic [7:0]       stage_q [0:4];

    logic             frame_valid_q;
    logic [7:0]       l1i_miss_q;
    logic [7:0]       l1i_acc_q;
    logic [7:0]       l1d_miss_q;
    logic [7:0]       l1d_acc_q;
    logic [7:0]       l2_miss_q;
    logic [7:0]       l2_acc_q;
    logic             frame_err_q;
    logic             gap_err_q;
    logic [CNT_W-1:0] frame_cnt_q;

    logic             frame_err_d;
    logic [CNT_W-1:0] frame_cnt_d;

`ifdef PERF_HITS_EN
    logic [7:0]       l1i_hit_q;
    logic [7:0]       l1d_hit_q;
    logic [7:0]       l2_hit_q;
    logic [7:0]       l1i_hit_d;
    logic [7:0]       l1d_hit_d;
    logic [7:0]       l2_hit_d;
`endif

    // Completion-time values, built from the five staged bytes plus the incoming sixth byte.
    always_comb begin
        frame_err_d = miss_gt_acc(stage_q[0], stage_q[1])
                    | miss_gt_acc(stage_q[2], stage_q[3])
                    | miss_gt_acc(stage_q[4], rx_data);
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
`ifdef PERF_HITS_EN
        l1i_hit_d = sat_hits(stage_q[1], stage_q[0]);
        l1d_hit_d = sat_hits(stage_q[3], stage_q[2]);
        l2_hit_d  = sat_hits(rx_data, stage_q[4]);
`endif
    end

    // Frame assembly FSM with gap timeout; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= 3'd0;
            timer_q       <= '0;
            for (int i = 0; i < 5; i++) begin
                stage_q[i] <= 8'd0;
            end
            frame_valid_q <= 1'b0;
            l1i_miss_q    <= 8'd0;
            l1i_acc_q     <= 8'd0;
            l1d_miss_q    <= 8'd0;
            l1d_acc_q     <= 8'd0;
            l2_miss_q     <= 8'd0;
            l2_acc_q      <= 8'd0;
            frame_err_q   <= 1'b0;
            gap_err_q     <= 1'b0;
            frame_cnt_q   <= '0;
`ifdef PERF_HITS_EN
            l1i_hit_q     <= 8'd0;
            l1d_hit_q     <= 8'd0;
            l2_hit_q      <= 8'd0;
`endif
        end else begin
            // Both strobes default low so each lasts exactly one cycle.
            frame_valid_q <= 1'b0;
            gap_err_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    timer_q <= '0;
                    if (rx_valid) begin
                        stage_q[0] <= rx_data;
                        idx_q      <= 3'd1;
                        state_q    <= S_COLLECT;
                    end else begin
                        idx_q      <= 3'd0;
                    end
                end
                S_COLLECT: begin
                    if (rx_valid) begin
                        // A byte always wins over a coincident timeout.
                        timer_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            l1i_miss_q    <= stage_q[0];
                            l1i_acc_q     <= stage_q[1];
                            l1d_miss_q    <= stage_q[2];
                            l1d_acc_q     <= stage_q[3];
                            l2_miss_q     <= stage_q[4];
                            l2_acc_q      <= rx_data;
                            frame_err_q   <= frame_err_d;
                            frame_cnt_q   <= frame_cnt_d;
                            frame_valid_q <= 1'b1;
`ifdef PERF_HITS_EN
                            l1i_hit_q     <= l1i_hit_d;
                            l1d_hit_q     <= l1d_hit_d;
                            l2_hit_q      <= l2_hit_d;
`endif
                            idx_q         <= 3'd0;
                            state_q       <= S_IDLE;
                        end else begin
                            stage_q[idx_q] <= rx_data;
                            idx_q          <= idx_q + 3'd1;
                        end
                    end else if (timer_q == TMR_LAST) begin
                        // Stalled partial frame: drop it, leave the held frame untouched.
                        gap_err_q <= 1'b1;
                        timer_q   <= '0;
                        idx_q     <= 3'd0;
                        state_q   <= S_IDLE;
                    end else begin
                        timer_q   <= timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    idx_q   <= 3'd0;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign frame_valid = frame_valid_q;
    assign l1i_miss    = l1i_miss_q;
    assign l1i_acc     = l1i_acc_q;
    assign l1d_miss    = l1d_miss_q;
    assign l1d_acc     = l1d_acc_q;
    assign l2_miss     = l2_miss_q;
    assign l2_acc      = l2_acc_q;
    assign frame_err   = frame_err_q;
    assign gap_err     = gap_err_q;
    assign frame_cnt   = frame_cnt_q;
`ifdef PERF_HITS_EN
    assign l1i_hit     = l1i_hit_q;
    assign l1d_hit     = l1d_hit_q;
    assign l2_hit      = l2_hit_q;
`endif

endmodule
